axil_master_engine: RTL and testbench

AXI4-Lite master. It turns single-cycle command strobes from local control logic into complete AXI4-Lite write and read transactions. It is the initiator counterpart of our AXI4-Lite slave register blocks and is used to drive their register maps from fabric state machines. The write and read paths are independent and may be in flight at the same time.

---
 rtl/axil_master_engine_pkg.sv | 30 +++
 rtl/axil_master_rd.sv | 115 +++++++++++
 rtl/axil_master_wr.sv | 156 +++++++++++++++
 rtl/axil_master_engine.sv | 95 +++++++++
 tb/tb_axil_master_engine.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_master_engine_pkg.sv
// ---------------------------------------------------------------------------
// axil_master_engine_pkg
// Shared definitions for the AXI4-Lite master engine: response codes,
// write/read FSM state encodings and the fixed protection attribute.
// ---------------------------------------------------------------------------
package axil_master_engine_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    // Unprivileged, secure, data access.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_master_rd.sv
// ---------------------------------------------------------------------------
// axil_master_rd
// Read path of the AXI4-Lite master: AR and R channels.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   rd_start, rd_addr           command strobe and latched address
//   rd_busy, rd_done            status back to the local controller
//   rd_data, rd_resp            captured read data/response, held after done
//   M_AXI_AR*/R*                AXI4-Lite read channels (outputs registered)
// ---------------------------------------------------------------------------
module axil_master_rd
    import axil_master_engine_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          rd_start,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_busy,
    output logic          rd_done,
    output logic [31:0]   rd_data,
    output logic [1:0]    rd_resp,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    input  logic [31:0]   M_AXI_RDATA,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY
);

    rd_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   data_q, data_d;
    logic [1:0]    resp_q, resp_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= R_IDLE;
            addr_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        data_d    = data_q;
        resp_d    = resp_q;

        case (state_q)
            R_IDLE: begin
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (rd_start) begin
                    addr_d    = rd_addr;
                    arvalid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = R_ADDR;
                end
            end
            R_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (M_AXI_RVALID) begin
                    data_d   = M_AXI_RDATA;
                    resp_d   = M_AXI_RRESP;
                    rready_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = R_IDLE;
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

    assign rd_busy       = busy_q;
    assign rd_done       = done_q;
    assign rd_data       = data_q;
    assign rd_resp       = resp_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: rtl/axil_master_wr.sv
// ---------------------------------------------------------------------------
// axil_master_wr
// Write path of the AXI4-Lite master: AW, W and B channels.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   wr_start/addr/data/strb     command strobe and latched operands
//   wr_busy, wr_done, wr_resp   status back to the local controller
//   M_AXI_AW*/W*/B*             AXI4-Lite write channels (outputs registered)
// ---------------------------------------------------------------------------
module axil_master_wr
    import axil_master_engine_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_start,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb,
    output logic          wr_busy,
    output logic          wr_done,
    output logic [1:0]    wr_resp,
    output logic [AW-1:0] M_AXI_AWADDR,
    output logic          M_AXI_AWVALID,
    input  logic          M_AXI_AWREADY,
    output logic [31:0]   M_AXI_WDATA,
    output logic [3:0]    M_AXI_WSTRB,
    output logic          M_AXI_WVALID,
    input  logic          M_AXI_WREADY,
    input  logic [1:0]    M_AXI_BRESP,
    input  logic          M_AXI_BVALID,
    output logic          M_AXI_BREADY
);

    wr_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    strb_q, strb_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    resp_q, resp_d;

    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q & M_AXI_WREADY;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= W_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        resp_d    = resp_q;

        case (state_q)
            W_IDLE: begin
                // The done cycle still counts as busy, so a start arriving
                // alongside wr_done is dropped rather than accepted.
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (wr_start) begin
                    addr_d    = wr_addr;
                    data_d    = wr_data;
                    strb_d    = wr_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = W_ADDR;
                end
            end
            W_ADDR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Both channels may finish in the same cycle or in either order.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = W_RESP;
                end
            end
            W_RESP: begin
                if (M_AXI_BVALID) begin
                    resp_d   = M_AXI_BRESP;
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = W_IDLE;
                end
            end
            default: begin
                state_d = W_IDLE;
            end
        endcase
    end

    assign wr_busy       = busy_q;
    assign wr_done       = done_q;
    assign wr_resp       = resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = strb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

endmodule

// File: rtl/axil_master_engine.sv
// ---------------------------------------------------------------------------
// axil_master_engine
// AXI4-Lite master: converts single-cycle write/read command strobes into
// complete AXI4-Lite transactions. Write and read paths run independently.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   wr_*              write command and status
//   rd_*              read command, status and captured data
//   M_AXI_*           AXI4-Lite master interface (PROT tied to 3'b000)
// ---------------------------------------------------------------------------
module axil_master_engine
    import axil_master_engine_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_start,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb,
    output logic          wr_busy,
    output logic          wr_done,
    output logic [1:0]    wr_resp,
    input  logic          rd_start,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_busy,
    output logic          rd_done,
    output logic [31:0]   rd_data,
    output logic [1:0]    rd_resp,
    output logic [AW-1:0] M_AXI_AWADDR,
    output logic          M_AXI_AWVALID,
    output logic [2:0]    M_AXI_AWPROT,
    input  logic          M_AXI_AWREADY,
    output logic [31:0]   M_AXI_WDATA,
    output logic [3:0]    M_AXI_WSTRB,
    output logic          M_AXI_WVALID,
    input  logic          M_AXI_WREADY,
    input  logic [1:0]    M_AXI_BRESP,
    input  logic          M_AXI_BVALID,
    output logic          M_AXI_BREADY,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    output logic [2:0]    M_AXI_ARPROT,
    input  logic          M_AXI_ARREADY,
    input  logic [31:0]   M_AXI_RDATA,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY
);

    assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
    assign M_AXI_ARPROT = AXI_PROT_DEFAULT;

    axil_master_wr #(.AW(AW)) u_wr (
        .clk           (clk),
        .resetn        (resetn),
        .wr_start      (wr_start),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_busy       (wr_busy),
        .wr_done       (wr_done),
        .wr_resp       (wr_resp),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY)
    );

    axil_master_rd #(.AW(AW)) u_rd (
        .clk           (clk),
        .resetn        (resetn),
        .rd_start      (rd_start),
        .rd_addr       (rd_addr),
        .rd_busy       (rd_busy),
        .rd_done       (rd_done),
        .rd_data       (rd_data),
        .rd_resp       (rd_resp),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

endmodule

// File: tb/tb_axil_master_engine.sv
// ---------------------------------------------------------------------------
// tb_axil_master_engine
// Directed bench for the AXI4-Lite master engine. The initial block plays
// both the local controller and the slave; a negedge monitor keeps a
// scoreboard of expected AW/W/AR payloads and of responses to be reported.
// ---------------------------------------------------------------------------
module tb_axil_master_engine;
    import axil_master_engine_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr_start;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic          wr_busy;
    logic          wr_done;
    logic [1:0]    wr_resp;
    logic          rd_start;
    logic [AW-1:0] rd_addr;
    logic          rd_busy;
    logic          rd_done;
    logic [31:0]   rd_data;
    logic [1:0]    rd_resp;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic [2:0]    awprot;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic [2:0]    arprot;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    always #5 clk = ~clk;

    axil_master_engine #(.AW(AW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .wr_start      (wr_start),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_busy       (wr_busy),
        .wr_done       (wr_done),
        .wr_resp       (wr_resp),
        .rd_start      (rd_start),
        .rd_addr       (rd_addr),
        .rd_busy       (rd_busy),
        .rd_done       (rd_done),
        .rd_data       (rd_data),
        .rd_resp       (rd_resp),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    int tests = 0;
    int fails = 0;
    int wr_done_cnt = 0;
    int rd_done_cnt = 0;

    // Scoreboard queues
    logic [AW-1:0] exp_aw_q[$];
    logic [35:0]   exp_w_q[$];
    logic [AW-1:0] exp_ar_q[$];
    logic [1:0]    exp_bresp_q[$];
    logic [33:0]   exp_r_q[$];

    logic          aw_seen = 1'b0;
    logic          w_seen  = 1'b0;
    logic          prev_awvalid = 1'b0;
    logic [AW-1:0] prev_awaddr  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sampled on the falling edge, i.e. the values the next rising
    // edge will act upon.
    always @(negedge clk) begin
        if (resetn) begin
            if (bready)
                check("bready_before_aw_w", {62'd0, aw_seen, w_seen}, 64'd3);
            if (awvalid && prev_awvalid)
                check("awaddr_stable", awaddr, prev_awaddr);
            if (awvalid && awready) begin
                aw_seen = 1'b1;
                if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
                else check("awaddr", awaddr, exp_aw_q.pop_front());
            end
            if (wvalid && wready) begin
                w_seen = 1'b1;
                if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
                else check("wdata_wstrb", {wdata, wstrb}, exp_w_q.pop_front());
            end
            if (bvalid && bready) exp_bresp_q.push_back(bresp);
            if (wr_done) begin
                wr_done_cnt++;
                aw_seen = 1'b0;
                w_seen  = 1'b0;
                if (exp_bresp_q.size() == 0) check("wr_done_unexpected", 1, 0);
                else check("wr_resp", wr_resp, exp_bresp_q.pop_front());
            end
            if (arvalid && arready) begin
                if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
                else check("araddr", araddr, exp_ar_q.pop_front());
            end
            if (rvalid && rready) exp_r_q.push_back({rdata, rresp});
            if (rd_done) begin
                rd_done_cnt++;
                if (exp_r_q.size() == 0) check("rd_done_unexpected", 1, 0);
                else check("rd_data_resp", {rd_data, rd_resp}, exp_r_q.pop_front());
            end
        end else begin
            aw_seen = 1'b0;
            w_seen  = 1'b0;
        end
        prev_awvalid = awvalid;
        prev_awaddr  = awaddr;
    end

    task automatic wait_wr(input int base);
        for (int i = 0; i < 50 && wr_done_cnt <= base; i++) tick();
        check("wr_done_timeout", {63'd0, wr_done_cnt > base}, 64'd1);
    endtask

    task automatic wait_rd(input int base);
        for (int i = 0; i < 50 && rd_done_cnt <= base; i++) tick();
        check("rd_done_timeout", {63'd0, rd_done_cnt > base}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_w;
        int base_r;

        resetn = 1'b0;
        wr_start = 0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        rd_start = 0; rd_addr = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = RESP_OKAY;
        arready = 0; rvalid = 0; rdata = '0; rresp = RESP_OKAY;
        repeat (3) tick();

        // Reset state
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        check("rst_status", {wr_busy, wr_done, rd_busy, rd_done}, 0);
        check("rst_data", {rd_data, rd_resp, wr_resp}, 0);
        check("rst_addr", {awaddr, araddr, wdata, wstrb}, 0);
        check("prot", {awprot, arprot}, 0);
        resetn = 1'b1;
        tick();
        $display("[TB] reset checked");

        // Write with all slave signals ready: minimum latency
        awready = 1; wready = 1; bvalid = 1; bresp = RESP_OKAY;
        wr_addr = 8'h04; wr_data = 32'hDEADBEEF; wr_strb = 4'hF; wr_start = 1;
        exp_aw_q.push_back(8'h04);
        exp_w_q.push_back({32'hDEADBEEF, 4'hF});
        tick(); wr_start = 0;                       // cycle 1
        check("w1_c1_valids", {awvalid, wvalid, wr_busy, bready}, 4'b1110);
        tick();                                     // cycle 2
        check("w1_c2", {awvalid, wvalid, bready, wr_done}, 4'b0010);
        tick();                                     // cycle 3
        check("w1_c3_done", {wr_done, wr_busy, bready, wr_resp}, 5'b11000);
        tick();
        check("w1_c4_idle", {wr_done, wr_busy}, 0);
        $display("[TB] write all-ready addr=0x04 data=0xDEADBEEF");

        // Split AW/W with BVALID already high (early B must wait)
        base_w = wr_done_cnt;
        awready = 0; wready = 1; bvalid = 1; bresp = RESP_SLVERR;
        wr_addr = 8'h10; wr_data = 32'hCAFEF00D; wr_strb = 4'h3; wr_start = 1;
        exp_aw_q.push_back(8'h10);
        exp_w_q.push_back({32'hCAFEF00D, 4'h3});
        tick(); wr_start = 0;                       // W handshake this cycle
        tick();
        check("split_wvalid_drop", {wvalid, awvalid, bready}, 3'b010);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("split_aw_hold", {awvalid, awaddr, bready}, {1'b1, 8'h10, 1'b0});
        end
        awready = 1;
        tick();                                     // AW handshake happened
        check("split_bready_up", {awvalid, bready}, 2'b01);
        wait_wr(base_w);
        repeat (3) tick();
        check("split_one_done", wr_done_cnt, base_w + 1);
        check("split_resp_held", wr_resp, RESP_SLVERR);
        $display("[TB] write split AW/W addr=0x10 resp=SLVERR");

        // Read with AR back-pressure and a DECERR response
        base_r = rd_done_cnt;
        arready = 0; rvalid = 0;
        rd_addr = 8'h08; rd_start = 1;
        exp_ar_q.push_back(8'h08);
        tick(); rd_start = 0;
        for (int i = 0; i < 3; i++) begin
            check("rd_arvalid_hold", {arvalid, araddr, rready, rd_busy}, {1'b1, 8'h08, 1'b0, 1'b1});
            tick();
        end
        arready = 1;
        tick(); arready = 0;
        check("rd_rready", {arvalid, rready}, 2'b01);
        rvalid = 1; rdata = 32'h12345678; rresp = RESP_DECERR;
        tick(); rvalid = 0;
        check("rd_done_pulse", {rd_done, rd_busy, rready}, 3'b110);
        check("rd_capture", {rd_data, rd_resp}, {32'h12345678, 2'b11});
        repeat (3) tick();
        check("rd_one_done", rd_done_cnt, base_r + 1);
        $display("[TB] read addr=0x08 data=0x12345678 resp=DECERR");

        // Concurrent write and read; second starts while busy are ignored
        base_w = wr_done_cnt; base_r = rd_done_cnt;
        awready = 1; wready = 1; bvalid = 1; bresp = RESP_EXOKAY;
        arready = 1; rvalid = 1; rdata = 32'hA5A50001; rresp = RESP_OKAY;
        wr_addr = 8'h20; wr_data = 32'h11112222; wr_strb = 4'h5; wr_start = 1;
        rd_addr = 8'h24; rd_start = 1;
        exp_aw_q.push_back(8'h20);
        exp_w_q.push_back({32'h11112222, 4'h5});
        exp_ar_q.push_back(8'h24);
        tick();
        wr_addr = 8'h30; wr_data = 32'h33334444; rd_addr = 8'h34;
        tick(); wr_start = 0; rd_start = 0;
        wait_wr(base_w);
        wait_rd(base_r);
        repeat (4) tick();
        check("conc_wr_once", wr_done_cnt, base_w + 1);
        check("conc_rd_once", rd_done_cnt, base_r + 1);
        check("conc_latched", {awaddr, wdata, araddr}, {8'h20, 32'h11112222, 8'h24});
        check("conc_idle", {wr_busy, rd_busy}, 0);
        $display("[TB] concurrent write 0x20 / read 0x24, busy starts ignored");

        // Reset in the middle of a read
        base_r = rd_done_cnt;
        arready = 0; rvalid = 0;
        rd_addr = 8'h40; rd_start = 1;
        tick(); rd_start = 0;
        check("rst_mid_arvalid", arvalid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_drop", {arvalid, rready, rd_busy, awvalid, wvalid, bready}, 0);
        tick();
        resetn = 1'b1;
        repeat (3) tick();
        check("rst_mid_no_done", rd_done_cnt, base_r);
        exp_ar_q.delete();
        exp_r_q.delete();
        arready = 1; rvalid = 1; rdata = 32'h0BADF00D; rresp = RESP_SLVERR;
        rd_addr = 8'h44; rd_start = 1;
        exp_ar_q.push_back(8'h44);
        tick(); rd_start = 0;
        wait_rd(base_r);
        check("rst_after_read", {rd_data, rd_resp}, {32'h0BADF00D, 2'b10});
        $display("[TB] reset mid-read abandoned, next read addr=0x44 ok");

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
